// File: rtl/arbiter_rr16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package arbiter_rr16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    // Saturation value of the per-grant hold counter.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder. The code word is {C, D, A, B} (C is the MSB),
// and output O(v+1) is high for code value v.
module decoder_4_16
    import arbiter_rr16_pkg::*;
(
    input  logic           A,
    input  logic           B,
    input  logic           C,
    input  logic           D,
    output logic [N_REQ:1] O
);

    assign O = N_REQ'(1) << {C, D, A, B};

endmodule

// File: rtl/arbiter_rr16.sv
// Round-robin arbiter for 16 requesters. Grants one requester at a time,
// holds the grant until release, requester drop or timeout, then inserts
// one idle turnaround cycle and moves the priority pointer past the winner.
module arbiter_rr16
    import arbiter_rr16_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = 8'd255
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout_flag
);

    // Last hold_cnt value before the grant is revoked; only used when TIMEOUT != 0.
    localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             flag_d;
    logic             rel_or_drop;
    logic             tmo_hit;
    logic [N_REQ:1]   dec_o;

    // Circular search: rotate so ptr sits at bit 0, take the lowest set bit,
    // then add ptr back (mod 16) to get the absolute requester index.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [IDX_W-1:0] p);
        logic [N_REQ-1:0] rot;
        logic [IDX_W-1:0] off;
        rot = N_REQ'({r, r} >> p);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        return off + p;
    endfunction

    // A holder-initiated end (strobe or dropped request) outranks the timeout.
    assign rel_or_drop = rel || !req[idx_q];
    assign tmo_hit     = (TIMEOUT != '0) && (hold_q == TO_LAST);

    // Next-state and next-value logic for the IDLE/GRANT machine.
    always_comb begin
        // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                hold_d = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_W'(1);
                if (rel_or_drop || tmo_hit) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    flag_d  = tmo_hit && !rel_or_drop;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            timeout_flag <= flag_d;
        end
    end

    decoder_4_16 u_dec (
        .A (idx_q[1]),
        .B (idx_q[0]),
        .C (idx_q[3]),
        .D (idx_q[2]),
        .O (dec_o)
    );

    assign busy    = (state_q == GRANT);
    assign gnt_idx = idx_q;
    assign gnt     = dec_o & {N_REQ{busy}};

endmodule

// File: tb/tb_arbiter_rr16.sv
// Self-checking bench for arbiter_rr16: two instances (TIMEOUT=4 and
// TIMEOUT=0) share stimulus and are compared every cycle against a
// behavioural model, with literal expectations pinned at key points.
module tb_arbiter_rr16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        rel;

    logic [15:0] gnt_a, gnt_b;
    logic [3:0]  idx_a, idx_b;
    logic        busy_a, busy_b;
    logic        flag_a, flag_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arbiter_rr16 #(.TIMEOUT(8'd4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rel          (rel),
        .gnt          (gnt_a),
        .gnt_idx      (idx_a),
        .busy         (busy_a),
        .timeout_flag (flag_a)
    );

    arbiter_rr16 #(.TIMEOUT(8'd0)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rel          (rel),
        .gnt          (gnt_b),
        .gnt_idx      (idx_b),
        .busy         (busy_b),
        .timeout_flag (flag_b)
    );

    // Behavioural model: count granted cycles, search circularly with a loop.
    typedef struct {
        bit busy;
        bit flag;
        int idx;
        int ptr;
        int cnt;
    } model_t;

    model_t m0, m1;
    bit     started = 1'b0;

    function automatic model_t model_next(input model_t s, input int t, input logic r,
                                          input logic [15:0] q, input logic rl);
        model_t n;
        bit     found;
        bit     by_holder;
        bit     by_time;
        n      = s;
        n.flag = 1'b0;
        found  = 1'b0;
        if (r) begin
            n.busy = 1'b0;
            n.idx  = 0;
            n.ptr  = 0;
            n.cnt  = 0;
        end else if (!s.busy) begin
            for (int k = 0; k < 16; k++) begin
                if (!found && q[(s.ptr + k) % 16]) begin
                    found  = 1'b1;
                    n.idx  = (s.ptr + k) % 16;
                    n.busy = 1'b1;
                    n.cnt  = 1;
                end
            end
        end else begin
            by_holder = rl || !q[s.idx];
            by_time   = (t != 0) && (s.cnt == t);
            if (by_holder || by_time) begin
                n.busy = 1'b0;
                n.ptr  = (s.idx + 1) % 16;
                n.flag = by_time && !by_holder;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_gnt(input model_t s);
        logic [15:0] g;
        g = s.busy ? (16'h0001 << s.idx) : 16'h0000;
        return g;
    endfunction

    always @(posedge clk) begin
        m0      <= model_next(m0, 4, rst, req, rel);
        m1      <= model_next(m1, 0, rst, req, rel);
        started <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pin a literal against both the DUT and the model.
    task automatic pin(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] lit);
        check({name, "_dut"}, dut_v, lit);
        check({name, "_model"}, mdl_v, lit);
    endtask

    // Per-cycle comparison of all outputs of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            check("gnt_a",  gnt_a,  exp_gnt(m0));
            check("idx_a",  idx_a,  m0.idx);
            check("busy_a", busy_a, m0.busy);
            check("flag_a", flag_a, m0.flag);
            check("gnt_b",  gnt_b,  exp_gnt(m1));
            check("idx_b",  idx_b,  m1.idx);
            check("busy_b", busy_b, m1.busy);
            check("flag_b", flag_b, m1.flag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keep the current grant for n cycles total, releasing with rel on the last one.
    task automatic hold_release(input int n);
        repeat (n - 1) step();
        rel = 1'b1;
        step();
        rel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at t=%0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = 16'h0000;
        rel = 1'b0;
        repeat (2) step();
        pin("rst_gnt",  gnt_a,  exp_gnt(m0), 16'h0000);
        pin("rst_busy", busy_a, m0.busy,     0);
        rst = 1'b0;

        // Idle with no requests.
        repeat (10) step();
        pin("idle_gnt", gnt_a, exp_gnt(m0), 16'h0000);
        pin("idle_idx", idx_a, m0.idx,      0);

        // Two requesters alternate with release after 3 granted cycles.
        req = 16'h0011;
        step();
        pin("t2_g0", gnt_a, exp_gnt(m0), 16'h0001);
        hold_release(3);
        pin("t2_turn", gnt_a, exp_gnt(m0), 16'h0000);
        step();
        pin("t2_g1", gnt_a, exp_gnt(m0), 16'h0010);
        hold_release(3);
        step();
        pin("t2_g2", gnt_a, exp_gnt(m0), 16'h0001);
        hold_release(3);

        // Pointer at 15 after granting 14, then wrap to 0.
        req = 16'h4000;
        step();
        pin("t3_g14", gnt_a, exp_gnt(m0), 16'h4000);
        hold_release(2);
        req = 16'h8001;
        step();
        pin("t3_g15", gnt_a, exp_gnt(m0), 16'h8000);
        hold_release(2);
        step();
        pin("t3_g0", gnt_a, exp_gnt(m0), 16'h0001);
        hold_release(2);

        // Timeout of 4 cycles on instance a; instance b keeps its grant.
        req = 16'h0008;
        for (int c = 1; c <= 4; c++) begin
            step();
            pin($sformatf("t4_c%0d", c), gnt_a, exp_gnt(m0), 16'h0008);
        end
        step();
        pin("t4_revoked", gnt_a,  exp_gnt(m0), 16'h0000);
        pin("t4_flag",    flag_a, m0.flag,     1);
        pin("t4_b_keeps", gnt_b,  exp_gnt(m1), 16'h0008);
        step();
        pin("t4_regrant",  gnt_a,  exp_gnt(m0), 16'h0008);
        pin("t4_flag_off", flag_a, m0.flag,     0);
        repeat (3) step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        pin("t4_rel_gnt",  gnt_a,  exp_gnt(m0), 16'h0000);
        pin("t4_rel_flag", flag_a, m0.flag,     0);
        req = 16'h0000;
        step();

        // Holder drops its request; pointer must land on 6.
        req = 16'h0020;
        step();
        pin("t5_g5", gnt_a, exp_gnt(m0), 16'h0020);
        repeat (2) step();
        req = 16'h0000;
        step();
        pin("t5_drop",      gnt_a,  exp_gnt(m0), 16'h0000);
        pin("t5_drop_flag", flag_a, m0.flag,     0);
        req = 16'h0041;
        step();
        pin("t5_ptr6", gnt_a, exp_gnt(m0), 16'h0040);
        rel = 1'b1;
        step();
        rel = 1'b0;

        // TIMEOUT=0 instance holds its grant for 300 cycles.
        req = 16'h0004;
        step();
        pin("t5_b_g2", gnt_b, exp_gnt(m1), 16'h0004);
        repeat (300) step();
        pin("t5_b_hold", gnt_b,  exp_gnt(m1), 16'h0004);
        pin("t5_b_busy", busy_b, m1.busy,     1);
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 16'h0000;
        step();

        // Reset in the middle of a grant, then first grant from pointer 0.
        req = 16'h0100;
        step();
        pin("t6_g8", gnt_a, exp_gnt(m0), 16'h0100);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pin("t6_rst_gnt",  gnt_a,  exp_gnt(m0), 16'h0000);
        pin("t6_rst_busy", busy_a, m0.busy,     0);
        pin("t6_rst_idx",  idx_a,  m0.idx,      0);
        req = 16'hFFFF;
        step();
        pin("t6_first_a", gnt_a, exp_gnt(m0), 16'h0001);
        pin("t6_first_b", gnt_b, exp_gnt(m1), 16'h0001);
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 16'h0000;
        step();

        // Randomized traffic, checked by the per-cycle compare process.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 16'h0000;
                    1:       req = 16'($urandom);
                    default: req = (16'h0001 << $urandom_range(0, 15)) |
                                   (16'h0001 << $urandom_range(0, 15));
                endcase
            end
            rel = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        rel = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_rr16.md
# arbiter_rr16

Round-robin arbiter that shares one 16-way resource among 16 requesters and drives the one-hot select through the existing 4-to-16 decoder. It accepts a request vector, grants exactly one requester at a time, and holds the grant until release, requester drop or timeout. After each release the priority pointer advances past the last winner. It sits between the requesting blocks and the decoder-selected resource.

## Interface
- `TIMEOUT`, default 255: maximum granted cycles per grant (8-bit); 0 disables the timeout.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  16  request vector; `req[k]` is held high by requester k while it wants the resource.
- `rel`  input  1  release strobe from the current holder; sampled only in GRANT.
- `gnt`  output  16  one-hot grant, or all zeros.
- `gnt_idx`  output  4  index of the current or last winner.
- `busy`  output  1  high while in GRANT.
- `timeout_flag`  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE (`busy`=0) and GRANT (`busy`=1).
- IDLE with `req`≠0:
  - Select the first set bit at or after `ptr`, searching circularly 15→0.
  - Load that index into `gnt_idx`, clear `hold_cnt`, and go to GRANT.
- IDLE with `req`=0: stay in IDLE; `gnt_idx` holds its value.
- GRANT: `hold_cnt` increments each cycle and saturates at 255. The grant is released on any of:
  - `rel`=1.
  - `req[gnt_idx]`=0 (requester drop).
  - `TIMEOUT`≠0 and `hold_cnt`==`TIMEOUT`-1.
- On release:
  - Go to IDLE.
  - `ptr` ← `gnt_idx`+1 mod 16 (15 wraps to 0).
  - `timeout_flag` ← 1 only if the timeout was the sole cause.
- Release causes in the same cycle: `rel` or requester drop takes precedence over timeout, so no flag.
- `gnt` = decode(`gnt_idx`) AND `busy`. It is never multi-hot and is zero in IDLE.
- After every release there is one mandatory IDLE cycle (turnaround); back-to-back grants are not allowed.
- Reset values: state IDLE, `ptr`=0, `gnt_idx`=0, `hold_cnt`=0. Outputs: `gnt`=0, `busy`=0, `timeout_flag`=0.
- Reset asserted mid-grant drops `gnt` on the next edge; `ptr` is not advanced.

## Timing
- `req` sampled at edge n in IDLE → `gnt`, `busy` and `gnt_idx` valid after edge n (1-cycle latency).
- Release condition sampled at edge m → `gnt`=0 and `timeout_flag` pulse after edge m. The earliest next grant is after edge m+1.
- Timeout: with `TIMEOUT`=T, `gnt` is high for exactly T cycles.
- All outputs are registered or derived only from registered state (the decode AND `busy`). There is no combinational path from `req` or `rel` to any output.

## Structure
- Shared package constants:
  - `N_REQ`=16, `IDX_W`=4.
  - State encoding IDLE=1'b0, GRANT=1'b1.
- Sub-module: reuse `decoder_4_16` for the one-hot grant.
  - Port mapping: C=`gnt_idx[3]`, D=`gnt_idx[2]`, A=`gnt_idx[1]`, B=`gnt_idx[0]`.
  - `gnt[k]` = O(k+1) AND `busy`.
- The circular priority search is a combinational function in this module (rotate by `ptr`, priority-encode, add back `ptr`).

## Test plan
- Reset, then `req`=16'h0000 for 10 cycles → `gnt`=0, `busy`=0, `gnt_idx`=0 throughout.
- `req`=16'h0011 held, `rel` pulsed after 3 granted cycles each time → grant sequence: `gnt`=16'h0001, then an IDLE cycle, then 16'h0010, then 16'h0001; `ptr` wraps correctly.
- `ptr`=15 (after granting requester 14), `req`=16'h8001 → next `gnt`=16'h8000, then 16'h0001 (wrap 15→0).
- `TIMEOUT`=4, `req[3]` held, `rel`=0 → `gnt`=16'h0008 for exactly 4 cycles, then `timeout_flag`=1 for one cycle and `gnt`=0. Also `rel`=1 on the 4th cycle → no `timeout_flag`.
- Holder drops `req[5]` mid-grant → `gnt`=0 on the next cycle, `ptr`=6. `TIMEOUT`=0 with `req[2]` held for 300 cycles → grant never revoked, `hold_cnt` saturates at 255.
- `rst` asserted while `gnt`=16'h0100 → next cycle `gnt`=0, `busy`=0, `gnt_idx`=0, `ptr`=0. First grant after reset with `req`=16'hFFFF → `gnt`=16'h0001.
